uart_sram_host: RTL and testbench
=================================

Name: uart_sram_host

Overview:
Host-side initiator for the UART SRAM load/dump protocol. It takes a request (write or read, 19-bit address, length) and serializes the command frame as bytes into an acia_tx instance. For writes it streams payload bytes from a ready/valid source. For reads it collects the returned bytes from an acia_rx instance and reports them downstream. It sits next to acia_tx and acia_rx in a tester or bridge FPGA, facing the SRAM loader across the serial link.

Parameters:
TIMEOUT, 4096, clk cycles allowed between read-response bytes (and before the first one) before the read is aborted.
TCW, $clog2(TIMEOUT+1), width of the timeout counter.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request strobe.
req_ready  out  1  high only in IDLE.
req_write  in  1  1 = write (0x57), 0 = read (0x52).
req_addr  in  19  SRAM start address.
req_len  in  8  byte count; 0 means 256.
wr_valid  in  1  write payload byte available.
wr_data  in  8  write payload byte.
wr_ready  out  1  payload byte is taken when wr_valid && wr_ready.
rd_valid  out  1  one-cycle pulse per received read byte.
rd_data  out  8  received byte; valid while rd_valid is high.
done  out  1  one-cycle pulse when a request completes.
timeout  out  1  one-cycle pulse when a read is aborted.
tx_dat  out  8  byte to acia_tx; registered.
tx_start  out  1  acia_tx trigger; registered; high for exactly one cycle per byte.
tx_busy  in  1  from acia_tx.
rx_dat  in  8  from acia_rx.
rx_stb  in  1  from acia_rx.

Behaviour:
- Reset: state IDLE; req_ready=1 on the cycle after reset deasserts; every other output 0; counters cleared.
- Reset mid-operation: aborts immediately. No further tx_start. done and timeout are not pulsed.
- Request accept: in IDLE, req_valid && req_ready latches cmd, addr and len.
  - cmd = 0x57 if req_write, else 0x52.
  - Internal remaining count is 9 bits; 0 loads as 256.
- Frame bytes, in order:
  - cmd
  - {5'b0, addr[18:16]}
  - addr[15:8]
  - addr[7:0]
  - len (raw req_len)
  - write only: payload bytes.
- Byte issue rule: a byte may be issued in a cycle where tx_busy==0 and the guard is clear.
  - Issue means: tx_dat and tx_start are registered, so they appear on the next cycle.
  - Guard: set for the tx_start cycle plus one following cycle; tx_busy is ignored while the guard is set.
- States and transitions:
  - IDLE -> S_CMD on accept.
  - S_CMD -> S_A2 -> S_A1 -> S_A0 -> S_LEN: each advances when its byte is issued.
  - S_LEN: after issuing len, go to S_WR if write, else go to S_RD in the same cycle, so RX capture starts while len is still shifting out.
- S_WR:
  - wr_ready = (tx_busy==0 && guard clear).
  - Each accepted wr_data is issued and decrements the count.
  - wr_valid low stalls with no timeout.
  - Remaining count 0: go to S_FLUSH.
- S_FLUSH:
  - Wait until the guard is clear and tx_busy==0.
  - Pulse done, go to IDLE.
- S_RD:
  - Each rx_stb gives rd_valid=1 and rd_data=rx_dat on the next cycle (latency 1); count decrements.
  - Count reaching 0: pulse done in the same cycle as the last rd_valid, then IDLE.
  - Timeout counter clears on entry and on every rx_stb, and increments otherwise.
  - Counter reaching TIMEOUT: pulse timeout (no done), go to IDLE. Bytes already delivered stay delivered.
- rx_stb outside S_RD is ignored: no rd_valid.
- req_valid outside IDLE is ignored.
- wr_ready is 0 outside S_WR.
- Addresses wrap inside the responder; this block does no address arithmetic.

Test Plan:
- Write req addr=0x12345, len=2, payload 0xAA,0x55 -> TX bytes 0x57,0x01,0x23,0x45,0x02,0xAA,0x55. Exactly 7 tx_start pulses, each issued only with tx_busy low. One done after the last byte finishes.
- Read req addr=0x7FFFF, len=3; responder model returns 0x10,0x20,0x30 -> TX 0x52,0x07,0xFF,0xFF,0x03. Three rd_valid pulses with those values. done coincides with the third rd_valid.
- Write len=0 -> len byte 0x00 on the wire. 256 payload bytes consumed. done once. wr_ready 0 afterwards.
- Read len=2, model returns only 0x99 -> one rd_valid (0x99). timeout pulses TIMEOUT cycles after that rx_stb. No done. req_ready returns to 1.
- Write len=4 with wr_valid dropped for 1000 cycles after byte 2 -> no timeout. Transfer resumes and completes with done.
- Reset asserted during S_A1 of a write -> tx_start stays 0 from then on. No done. Next request after reset produces a correct full frame.

Source files
------------

// File: rtl/uart_sram_host.sv
`default_nettype none
// ============================================================================
// Module      : uart_sram_host
// Description : Host-side initiator for the UART SRAM load/dump protocol.
//               Serialises a command frame (cmd, addr[18:16], addr[15:8],
//               addr[7:0], len) into acia_tx, streams write payload from a
//               ready/valid source, and collects read data from acia_rx with
//               an inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sram_host #(
    parameter int TIMEOUT = 4096,
    parameter int TCW     = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [18:0] req_addr,
    input  logic [7:0]  req_len,
    // write payload channel
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    // read data channel
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    // status
    output logic        done,
    output logic        timeout,
    // acia_tx side
    output logic [7:0]  tx_dat,
    output logic        tx_start,
    input  logic        tx_busy,
    // acia_rx side
    input  logic [7:0]  rx_dat,
    input  logic        rx_stb
);

    localparam logic [7:0]     c_cmd_write   = 8'h57;
    localparam logic [7:0]     c_cmd_read    = 8'h52;
    localparam logic [TCW-1:0] c_timeout_val = TCW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CMD   = 4'd1,
        S_A2    = 4'd2,
        S_A1    = 4'd3,
        S_A0    = 4'd4,
        S_LEN   = 4'd5,
        S_WR    = 4'd6,
        S_FLUSH = 4'd7,
        S_RD    = 4'd8
    } state_t;

    state_t         r_state;
    logic           r_write;
    logic [18:0]    r_addr;
    logic [7:0]     r_len;
    logic [8:0]     r_cnt;      // remaining payload/response bytes, 1..256
    logic [1:0]     r_guard;    // masks tx_busy until acia_tx has had time to raise it
    logic [TCW-1:0] r_tcnt;
    logic [7:0]     r_tx_dat;
    logic           r_tx_start;
    logic           r_rd_valid;
    logic [7:0]     r_rd_data;
    logic           r_done;
    logic           r_timeout;

    logic           w_can_issue;
    logic [7:0]     w_hdr_byte;
    state_t         w_hdr_next;
    logic [TCW-1:0] w_tcnt_next;

    assign w_can_issue = !tx_busy && (r_guard == 2'd0);
    assign w_tcnt_next = r_tcnt + TCW'(1);

    assign req_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_WR) && w_can_issue && (r_cnt != 9'd0);
    assign tx_dat    = r_tx_dat;
    assign tx_start  = r_tx_start;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign timeout   = r_timeout;

    // Header byte for the current frame state and the state that follows it
    always_comb begin
        w_hdr_byte = 8'h00;
        w_hdr_next = S_IDLE;
        case (r_state)
            S_CMD: begin
                w_hdr_byte = r_write ? c_cmd_write : c_cmd_read;
                w_hdr_next = S_A2;
            end
            S_A2: begin
                w_hdr_byte = {5'b00000, r_addr[18:16]};
                w_hdr_next = S_A1;
            end
            S_A1: begin
                w_hdr_byte = r_addr[15:8];
                w_hdr_next = S_A0;
            end
            S_A0: begin
                w_hdr_byte = r_addr[7:0];
                w_hdr_next = S_LEN;
            end
            S_LEN: begin
                w_hdr_byte = r_len;
                // Go straight to read capture so response bytes arriving while
                // len is still shifting out are not lost.
                w_hdr_next = r_write ? S_WR : S_RD;
            end
            default: begin
                w_hdr_byte = 8'h00;
                w_hdr_next = S_IDLE;
            end
        endcase
    end

    // Protocol FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_addr     <= 19'd0;
            r_len      <= 8'd0;
            r_cnt      <= 9'd0;
            r_guard    <= 2'd0;
            r_tcnt     <= '0;
            r_tx_dat   <= 8'd0;
            r_tx_start <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'd0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_len   <= req_len;
                        // len 0 encodes 256
                        r_cnt   <= {(req_len == 8'd0), req_len};
                        r_state <= S_CMD;
                    end
                end

                S_CMD, S_A2, S_A1, S_A0, S_LEN: begin
                    if (w_can_issue) begin
                        r_tx_dat   <= w_hdr_byte;
                        r_tx_start <= 1'b1;
                        r_guard    <= 2'd2;
                        r_tcnt     <= '0;
                        r_state    <= w_hdr_next;
                    end
                end

                S_WR: begin
                    if (r_cnt == 9'd0) begin
                        r_state <= S_FLUSH;
                    end else if (wr_valid && w_can_issue) begin
                        r_tx_dat   <= wr_data;
                        r_tx_start <= 1'b1;
                        r_guard    <= 2'd2;
                        r_cnt      <= r_cnt - 9'd1;
                    end
                end

                S_FLUSH: begin
                    // Last payload byte has fully left acia_tx
                    if (w_can_issue) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_RD: begin
                    if (rx_stb) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= rx_dat;
                        r_cnt      <= r_cnt - 9'd1;
                        r_tcnt     <= '0;
                        if (r_cnt == 9'd1) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (w_tcnt_next == c_timeout_val) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_sram_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_sram_host
// Description : Directed self-checking bench for uart_sram_host with an
//               acia_tx busy model, frame/response scoreboards and literal
//               frame expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sram_host;

    localparam int TO       = 200;
    localparam int BYTE_CYC = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [18:0] req_addr = 19'd0;
    logic [7:0]  req_len = 8'd0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done;
    logic        timeout;
    logic [7:0]  tx_dat;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_dat = 8'd0;
    logic        rx_stb = 1'b0;

    always #5 clk = ~clk;

    uart_sram_host #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .timeout   (timeout),
        .tx_dat    (tx_dat),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .rx_dat    (rx_dat),
        .rx_stb    (rx_stb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // acia_tx model: busy for BYTE_CYC cycles starting the cycle after tx_start
    int bcnt = 0;
    always @(posedge clk) begin
        if (tx_start) bcnt <= BYTE_CYC;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] tx_log[$];
    int  done_seen = 0;
    int  to_seen   = 0;
    int  rdv_seen  = 0;
    bit  cur_read  = 1'b0;
    bit  busy_prev = 1'b0;
    int  last_start = -100;
    int  last_stb   = 0;

    logic [7:0] lit_wr [7] = '{8'h57, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAA, 8'h55};
    logic [7:0] lit_rd [5] = '{8'h52, 8'h07, 8'hFF, 8'hFF, 8'h03};
    logic [7:0] lit_rs [6] = '{8'h57, 8'h00, 8'hF0, 8'hF0, 8'h01, 8'h3C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the scoreboards
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_start) begin
                check("tx_start_busy_low", {31'd0, busy_prev}, 32'd0);
                check("tx_start_spacing", {31'd0, (cyc - last_start) >= 3}, 32'd1);
                last_start = cyc;
                tx_log.push_back(tx_dat);
                check("tx_pending", {31'd0, exp_tx.size() != 0}, 32'd1);
                if (exp_tx.size() != 0) check("tx_dat", {24'd0, tx_dat}, {24'd0, exp_tx.pop_front()});
            end
            if (rd_valid) begin
                rdv_seen++;
                check("rd_pending", {31'd0, exp_rd.size() != 0}, 32'd1);
                if (exp_rd.size() != 0) check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
            end
            if (done) begin
                done_seen++;
                if (cur_read) check("done_with_last_rd", {30'd0, rd_valid, exp_rd.size() == 0}, 32'd3);
                else          check("done_after_tx_idle", {31'd0, tx_busy}, 32'd0);
            end
            if (timeout) begin
                to_seen++;
                check("timeout_delay", cyc - last_stb, TO + 1);
            end
            if (wr_ready) check("wr_ready_tx_idle", {31'd0, tx_busy}, 32'd0);
            if (rx_stb) last_stb = cyc;
        end
        busy_prev = tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input bit w, input logic [18:0] a, input logic [7:0] l);
        bit ok = 1'b0;
        exp_tx.push_back(w ? 8'h57 : 8'h52);
        exp_tx.push_back({5'd0, a[18:16]});
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
        exp_tx.push_back(l);
        cur_read  = !w;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("req_accepted", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok = 1'b0;
        exp_tx.push_back(b);
        wr_valid = 1'b1;
        wr_data  = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1'b1; break; end
        end
        check("wr_byte_taken", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap, input bit expect_it);
        if (expect_it) exp_rd.push_back(b);
        tick(gap);
        rx_stb = 1'b1;
        rx_dat = b;
        tick(1);
        rx_stb = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc && exp_tx.size() != 0; i++) @(negedge clk);
        check("frame_sent", exp_tx.size(), 32'd0);
        tick(1);
    endtask

    task automatic wait_end(input int maxc);
        int d0 = done_seen;
        int t0 = to_seen;
        bit ended = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done_seen != d0 || to_seen != t0) begin ended = 1'b1; break; end
        end
        check("xfer_ended", {31'd0, ended}, 32'd1);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t0, r0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_outputs", {26'd0, wr_ready, rd_valid, done, timeout, tx_start, 1'b0}, 32'd0);
        check("reset_data", {16'd0, tx_dat, rd_data}, 32'd0);
        tick(1);

        // Write 2 bytes at 0x12345
        tx_log.delete();
        d0 = done_seen; t0 = to_seen;
        send_req(1'b1, 19'h12345, 8'd2);
        push_byte(8'hAA);
        push_byte(8'h55);
        wait_end(500);
        check("wr1_done_count", done_seen - d0, 32'd1);
        check("wr1_no_timeout", to_seen - t0, 32'd0);
        check("wr1_tx_count", tx_log.size(), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < tx_log.size()) check("wr1_literal_byte", {24'd0, tx_log[i]}, {24'd0, lit_wr[i]});
        @(negedge clk);
        check("wr1_idle_ready", {30'd0, req_ready, wr_ready}, 32'd2);
        tick(1);

        // Read 3 bytes at 0x7FFFF
        tx_log.delete();
        d0 = done_seen; r0 = rdv_seen;
        send_req(1'b0, 19'h7FFFF, 8'd3);
        wait_drain(200);
        send_rx(8'h10, 4, 1'b1);
        send_rx(8'h20, 7, 1'b1);
        send_rx(8'h30, 3, 1'b1);
        wait_end(100);
        check("rd1_rdv_count", rdv_seen - r0, 32'd3);
        check("rd1_done_count", done_seen - d0, 32'd1);
        check("rd1_tx_count", tx_log.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < tx_log.size()) check("rd1_literal_byte", {24'd0, tx_log[i]}, {24'd0, lit_rd[i]});

        // Write len 0 = 256 bytes
        tx_log.delete();
        d0 = done_seen;
        send_req(1'b1, 19'h00100, 8'd0);
        for (int i = 0; i < 256; i++) push_byte(8'(i ^ 8'h5A));
        wait_end(500);
        check("wr256_done_count", done_seen - d0, 32'd1);
        check("wr256_tx_count", tx_log.size(), 32'd261);
        if (tx_log.size() > 4) check("wr256_len_byte", {24'd0, tx_log[4]}, 32'd0);
        @(negedge clk);
        check("wr256_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        tick(1);

        // Read len 2, only one byte arrives -> timeout
        d0 = done_seen; t0 = to_seen; r0 = rdv_seen;
        send_req(1'b0, 19'h00042, 8'd2);
        wait_drain(200);
        send_rx(8'h99, 5, 1'b1);
        wait_end(TO + 50);
        check("rdto_timeout_count", to_seen - t0, 32'd1);
        check("rdto_no_done", done_seen - d0, 32'd0);
        check("rdto_rdv_count", rdv_seen - r0, 32'd1);
        exp_rd.delete();
        @(negedge clk);
        check("rdto_req_ready", {31'd0, req_ready}, 32'd1);
        tick(1);

        // Stray rx_stb in IDLE is ignored
        r0 = rdv_seen;
        send_rx(8'hEE, 2, 1'b0);
        tick(5);
        check("idle_rx_ignored", rdv_seen - r0, 32'd0);

        // Write len 4 with a long payload stall
        d0 = done_seen; t0 = to_seen;
        send_req(1'b1, 19'h00ABC, 8'd4);
        push_byte(8'h01);
        push_byte(8'h02);
        tick(1000);
        push_byte(8'h03);
        push_byte(8'h04);
        wait_end(500);
        check("stall_no_timeout", to_seen - t0, 32'd0);
        check("stall_done_count", done_seen - d0, 32'd1);

        // Reset in the middle of a write frame (during S_A1)
        tx_log.delete();
        d0 = done_seen;
        send_req(1'b1, 19'h54321, 8'd3);
        for (int i = 0; i < 100 && tx_log.size() < 2; i++) @(negedge clk);
        check("rst_two_bytes_out", tx_log.size(), 32'd2);
        reset = 1'b1;
        exp_tx.delete();
        tick(2);
        reset = 1'b0;
        tick(60);
        check("rst_no_more_tx", tx_log.size(), 32'd2);
        check("rst_no_done", done_seen - d0, 32'd0);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        tick(1);

        tx_log.delete();
        d0 = done_seen;
        send_req(1'b1, 19'h0F0F0, 8'd1);
        push_byte(8'h3C);
        wait_end(500);
        check("post_rst_done", done_seen - d0, 32'd1);
        check("post_rst_tx_count", tx_log.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < tx_log.size()) check("post_rst_literal_byte", {24'd0, tx_log[i]}, {24'd0, lit_rs[i]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
